// File: rtl/gst_snd_pkg.sv
// Shared constants, register map and FSM state type for the STE DMA-sound frame controller.
package gst_snd_pkg;

  localparam int unsigned ADDR_W          = 23;
  localparam int unsigned HOLD_CYCLES_DEF = 4;

  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_START_H = 4'd1;
  localparam logic [3:0] REG_START_M = 4'd2;
  localparam logic [3:0] REG_START_L = 4'd3;
  localparam logic [3:0] REG_CNT_H   = 4'd4;
  localparam logic [3:0] REG_CNT_M   = 4'd5;
  localparam logic [3:0] REG_CNT_L   = 4'd6;
  localparam logic [3:0] REG_END_H   = 4'd7;
  localparam logic [3:0] REG_END_M   = 4'd8;
  localparam logic [3:0] REG_END_L   = 4'd9;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_LOAD, ST_HOLD} snd_state_e;

  // Byte view of a word address: sel 2 = bits [23:16], 1 = [15:8], 0 = [7:1] with bit 0 reading 0.
  function automatic logic [7:0] addr_byte(input logic [ADDR_W-1:0] a, input logic [1:0] sel);
    case (sel)
      2'd2:    addr_byte = a[22:15];
      2'd1:    addr_byte = a[14:7];
      default: addr_byte = {a[6:0], 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/gst_snd_dma.sv
// DMA-sound frame controller: frame registers, word fetch sequencing toward the shifter FIFO,
// and frame-end reporting.
module gst_snd_dma
  import gst_snd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic        clk32,
  input  logic        resb,
  input  logic        CS,
  input  logic [6:1]  A,
  input  logic        RW,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  input  logic        SREQ,
  output logic        MREQ,
  output logic [23:1] ADDR,
  input  logic        ACK,
  output logic        SLOAD_N,
  output logic        SACTIVE,
  output logic        FRAME_END
);

  localparam int unsigned TMR_W = $clog2(HOLD_CYCLES + 1);

  snd_state_e        state;
  logic              ena;
  logic              lp;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] end_l;
  logic [TMR_W-1:0]  tmr;
  logic              cs_wr_q;
  logic              chk_inc;
  logic              chk_load;
  logic              wr_stb;
  logic [3:0]        idx;
  logic [7:0]        rd_byte;
  logic              unused_bits;

  assign idx         = A[4:1];
  assign wr_stb      = CS & ~RW & ~cs_wr_q;
  assign SACTIVE     = ena;
  assign unused_bits = ^{A[6:5], DIN[15:8]};

  // Fetch sequencer, frame-end handling and CPU register writes (CPU writes take priority).
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state     <= ST_IDLE;
      ena       <= 1'b0;
      lp        <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
      cnt       <= '0;
      end_l     <= '0;
      tmr       <= '0;
      cs_wr_q   <= 1'b0;
      chk_inc   <= 1'b0;
      chk_load  <= 1'b0;
      MREQ      <= 1'b0;
      ADDR      <= '0;
      SLOAD_N   <= 1'b1;
      FRAME_END <= 1'b0;
    end else begin
      FRAME_END <= 1'b0;
      chk_inc   <= 1'b0;
      chk_load  <= 1'b0;
      cs_wr_q   <= CS & ~RW;

      case (state)
        ST_IDLE: begin
          if (ena && (cnt != end_l) && SREQ) begin
            state <= ST_REQ;
            MREQ  <= 1'b1;
            ADDR  <= cnt;
          end
        end
        ST_REQ: begin
          if (ACK && MREQ) begin
            cnt     <= cnt + ADDR_W'(1);
            MREQ    <= 1'b0;
            SLOAD_N <= 1'b0;
            tmr     <= '0;
            chk_inc <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (tmr == TMR_W'(1)) begin
            SLOAD_N <= 1'b1;
            tmr     <= '0;
            state   <= ST_HOLD;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_HOLD: begin
          if (tmr == TMR_W'(HOLD_CYCLES - 1)) begin
            state <= ST_IDLE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // An empty frame at load always stops; a frame reached by fetching may loop.
      if ((chk_inc || chk_load) && (cnt == end_l)) begin
        FRAME_END <= 1'b1;
        if (chk_inc && lp && ena) begin
          cnt      <= start_q;
          end_l    <= end_q;
          chk_load <= 1'b1;
        end else begin
          ena <= 1'b0;
        end
      end

      if (wr_stb) begin
        case (idx)
          REG_CTRL: begin
            ena <= DIN[0];
            lp  <= DIN[1];
            if (DIN[0] && !ena) begin
              cnt      <= start_q;
              end_l    <= end_q;
              chk_load <= 1'b1;
            end
          end
          REG_START_H: start_q[22:15] <= DIN[7:0];
          REG_START_M: start_q[14:7]  <= DIN[7:0];
          REG_START_L: start_q[6:0]   <= DIN[7:1];
          REG_END_H:   end_q[22:15]   <= DIN[7:0];
          REG_END_M:   end_q[14:7]    <= DIN[7:0];
          REG_END_L:   end_q[6:0]     <= DIN[7:1];
          default: ;
        endcase
      end
    end
  end

  // Combinational register read path.
  always_comb begin
    rd_byte = 8'h00;
    case (idx)
      REG_CTRL:    rd_byte = {6'b0, lp, ena};
      REG_START_H: rd_byte = addr_byte(start_q, 2'd2);
      REG_START_M: rd_byte = addr_byte(start_q, 2'd1);
      REG_START_L: rd_byte = addr_byte(start_q, 2'd0);
      REG_CNT_H:   rd_byte = addr_byte(cnt, 2'd2);
      REG_CNT_M:   rd_byte = addr_byte(cnt, 2'd1);
      REG_CNT_L:   rd_byte = addr_byte(cnt, 2'd0);
      REG_END_H:   rd_byte = addr_byte(end_q, 2'd2);
      REG_END_M:   rd_byte = addr_byte(end_q, 2'd1);
      REG_END_L:   rd_byte = addr_byte(end_q, 2'd0);
      default:     rd_byte = 8'h00;
    endcase
    DOUT = (CS && RW) ? {8'h00, rd_byte} : 16'h0000;
  end

endmodule

// File: tb/tb_gst_snd_dma.sv
// Scoreboard bench for gst_snd_dma: expected fetch addresses and frame ends are queued by the
// stimulus; a monitor compares them as the DUT raises MREQ and FRAME_END.
module tb_gst_snd_dma;

  logic        clk32 = 1'b0;
  logic        resb;
  logic        CS;
  logic [6:1]  A;
  logic        RW;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic        SREQ;
  logic        MREQ;
  logic [23:1] ADDR;
  logic        ACK;
  logic        SLOAD_N;
  logic        SACTIVE;
  logic        FRAME_END;

  int checks = 0;
  int fails  = 0;
  logic [22:0] exp_addr_q[$];
  int          exp_fe_q[$];
  int n_push  = 0;
  int n_seen  = 0;
  int n_fe    = 0;
  int n_sload = 0;
  int ack_dly = 2;
  int mcyc    = 0;
  logic mon_mreq_d = 1'b0;
  int   mon_run    = 0;

  gst_snd_dma dut (
    .clk32(clk32), .resb(resb), .CS(CS), .A(A), .RW(RW), .DIN(DIN), .DOUT(DOUT),
    .SREQ(SREQ), .MREQ(MREQ), .ADDR(ADDR), .ACK(ACK), .SLOAD_N(SLOAD_N),
    .SACTIVE(SACTIVE), .FRAME_END(FRAME_END)
  );

  always #5 clk32 = ~clk32;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [7:0] d);
    CS = 1'b1; RW = 1'b0; A = {2'b00, idx}; DIN = {8'h00, d};
    tick();
    CS = 1'b0; RW = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [3:0] idx, input logic [7:0] exp, input string name);
    CS = 1'b1; RW = 1'b1; A = {2'b00, idx};
    @(negedge clk32);
    chk(name, 32'(DOUT), {24'h0, exp});
    tick();
    CS = 1'b0;
  endtask

  task automatic set_frame(input logic [23:0] s, input logic [23:0] e);
    wr(4'd1, s[23:16]); wr(4'd2, s[15:8]); wr(4'd3, s[7:0]);
    wr(4'd7, e[23:16]); wr(4'd8, e[15:8]); wr(4'd9, e[7:0]);
  endtask

  task automatic push_fetch(input logic [22:0] a);
    exp_addr_q.push_back(a);
    n_push++;
  endtask

  task automatic push_fe();
    exp_fe_q.push_back(n_push);
  endtask

  task automatic wait_fe(input int target, input int budget, input string name);
    int i = 0;
    while (n_fe < target && i < budget) begin tick(); i++; end
    chk(name, 32'(n_fe), 32'(target));
  endtask

  task automatic wait_fetch(input int target, input int budget, input string name);
    int i = 0;
    while (n_seen < target && i < budget) begin tick(); i++; end
    chk(name, 32'(n_seen), 32'(target));
  endtask

  // Arbiter model: ACK one cycle, ack_dly cycles after MREQ rises.
  initial begin
    ACK = 1'b0;
    forever begin
      @(posedge clk32);
      #1;
      ACK = 1'b0;
      if (MREQ) begin
        mcyc++;
        if (mcyc == ack_dly) ACK = 1'b1;
      end else begin
        mcyc = 0;
      end
    end
  end

  // Monitor: fetch addresses, frame-end fetch counts and load-pulse widths.
  initial begin
    forever begin
      @(negedge clk32);
      if (MREQ && !mon_mreq_d) begin
        n_seen++;
        if (exp_addr_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL fetch_unexpected: got ADDR %h with no fetch expected", ADDR);
        end else begin
          chk("fetch_addr", 32'(ADDR), 32'(exp_addr_q.pop_front()));
        end
      end
      mon_mreq_d = MREQ;
      if (FRAME_END) begin
        n_fe++;
        if (exp_fe_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL frame_end_unexpected: got FRAME_END after %0d fetches, none expected", n_seen);
        end else begin
          chk("frame_end_fetches", 32'(n_seen), 32'(exp_fe_q.pop_front()));
        end
      end
      if (!SLOAD_N) begin
        mon_run++;
      end else if (mon_run != 0) begin
        n_sload++;
        chk("sload_width", 32'(mon_run), 32'd2);
        mon_run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    int fe_base;
    int sl_base;
    int mcount;
    resb = 1'b0; CS = 1'b0; RW = 1'b1; A = '0; DIN = '0; SREQ = 1'b1;
    repeat (3) tick();
    chk("rst_mreq", 32'(MREQ), 32'd0);
    chk("rst_sload_n", 32'(SLOAD_N), 32'd1);
    chk("rst_sactive", 32'(SACTIVE), 32'd0);
    chk("rst_frame_end", 32'(FRAME_END), 32'd0);
    chk("rst_addr", 32'(ADDR), 32'd0);
    resb = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) rd(4'(i), 8'h00, "rst_reg");
    chk("dout_no_cs", 32'(DOUT), 32'd0);

    // Single frame, no loop.
    set_frame(24'h010000, 24'h010008);
    for (int i = 0; i < 4; i++) push_fetch(23'h008000 + 23'(i));
    push_fe();
    wr(4'd0, 8'h01);
    chk("play_sactive_on", 32'(SACTIVE), 32'd1);
    wait_fe(1, 200, "play_fe_wait");
    repeat (15) tick();
    chk("play_sactive_off", 32'(SACTIVE), 32'd0);
    chk("play_sload_count", 32'(n_sload), 32'd4);
    rd(4'd0, 8'h00, "play_ctrl");
    rd(4'd4, 8'h01, "play_cnt_h");
    rd(4'd6, 8'h08, "play_cnt_l");
    wr(4'd6, 8'h55);
    rd(4'd6, 8'h08, "cnt_write_ignored");
    rd(4'd3, 8'h00, "start_l_read");

    // Looping; end shortened mid-frame takes effect on the following frame.
    set_frame(24'h010000, 24'h010008);
    for (int i = 0; i < 4; i++) push_fetch(23'h008000 + 23'(i));
    push_fe();
    for (int f = 0; f < 2; f++) begin
      push_fetch(23'h008000); push_fetch(23'h008001); push_fe();
    end
    base = n_seen; fe_base = n_fe;
    wr(4'd0, 8'h03);
    wait_fetch(base + 1, 50, "loop_first_fetch");
    wr(4'd9, 8'h04);
    wait_fe(fe_base + 3, 500, "loop_fe_wait");
    wr(4'd0, 8'h00);
    repeat (15) tick();
    rd(4'd0, 8'h00, "loop_ctrl_off");
    rd(4'd4, 8'h01, "loop_cnt_h");
    rd(4'd6, 8'h00, "loop_cnt_reloaded");
    rd(4'd9, 8'h04, "loop_end_l_reg");

    // SREQ stall mid-frame.
    set_frame(24'h010000, 24'h010008);
    for (int i = 0; i < 4; i++) push_fetch(23'h008000 + 23'(i));
    push_fe();
    base = n_seen; fe_base = n_fe;
    wr(4'd0, 8'h01);
    wait_fetch(base + 2, 100, "stall_pre_fetch");
    SREQ = 1'b0;
    repeat (12) tick();
    rd(4'd6, 8'h04, "stall_cnt_a");
    mcount = 0;
    repeat (40) begin
      @(negedge clk32);
      if (MREQ) mcount++;
    end
    tick();
    chk("stall_mreq_cycles", 32'(mcount), 32'd0);
    rd(4'd6, 8'h04, "stall_cnt_b");
    SREQ = 1'b1;
    wait_fe(fe_base + 1, 200, "stall_fe_wait");
    repeat (15) tick();

    // CPU disable while MREQ is high.
    ack_dly = 6;
    set_frame(24'h010000, 24'h010008);
    push_fetch(23'h008000);
    base = n_seen;
    wr(4'd0, 8'h01);
    wait_fetch(base + 1, 50, "dis_fetch_wait");
    sl_base = n_sload;
    wr(4'd0, 8'h00);
    chk("dis_mreq_held", 32'(MREQ), 32'd1);
    chk("dis_sactive", 32'(SACTIVE), 32'd0);
    repeat (40) tick();
    chk("dis_sload_pulses", 32'(n_sload), 32'(sl_base + 1));
    rd(4'd6, 8'h02, "dis_cnt_l");
    ack_dly = 2;

    // Empty frame, without and with loop.
    set_frame(24'h020000, 24'h020000);
    push_fe();
    wr(4'd0, 8'h01);
    repeat (10) tick();
    chk("empty_sactive", 32'(SACTIVE), 32'd0);
    chk("empty_fe_seen", 32'(exp_fe_q.size()), 32'd0);
    rd(4'd4, 8'h02, "empty_cnt_h");
    push_fe();
    wr(4'd0, 8'h03);
    repeat (10) tick();
    chk("empty_loop_sactive", 32'(SACTIVE), 32'd0);
    rd(4'd0, 8'h02, "empty_loop_ctrl");
    wr(4'd0, 8'h00);

    // Counter wrap across the top of the address space.
    set_frame(24'hFFFFFC, 24'h000002);
    push_fetch(23'h7FFFFE); push_fetch(23'h7FFFFF); push_fetch(23'h000000);
    push_fe();
    fe_base = n_fe;
    wr(4'd0, 8'h01);
    wait_fe(fe_base + 1, 200, "wrap_fe_wait");
    repeat (15) tick();
    chk("wrap_sactive", 32'(SACTIVE), 32'd0);
    rd(4'd4, 8'h00, "wrap_cnt_h");
    rd(4'd6, 8'h02, "wrap_cnt_l");

    // Asynchronous reset in the middle of a fetch.
    ack_dly = 1000;
    set_frame(24'h010000, 24'h010008);
    push_fetch(23'h008000);
    base = n_seen;
    wr(4'd0, 8'h01);
    wait_fetch(base + 1, 50, "rst_fetch_wait");
    #2 resb = 1'b0;
    #1;
    chk("arst_mreq", 32'(MREQ), 32'd0);
    chk("arst_sload_n", 32'(SLOAD_N), 32'd1);
    chk("arst_addr", 32'(ADDR), 32'd0);
    tick();
    for (int i = 0; i < 10; i++) rd(4'(i), 8'h00, "arst_reg");
    resb = 1'b1;
    ack_dly = 2;
    repeat (10) tick();

    chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("fe_q_drained", 32'(exp_fe_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
